// File: rtl/apb2axi_gateway_tagged_pkg.sv
// Shared types for the APB-to-AXI tagged descriptor gateway.
// Directory entry, completion record, control register and map offsets.
package apb2axi_gateway_tagged_pkg;

  localparam int unsigned ADDR_MAX_W = 64;

  localparam int unsigned OFF_ADDR_LO = 'h00;
  localparam int unsigned OFF_ADDR_HI = 'h04;
  localparam int unsigned OFF_CTRL    = 'h08;
  localparam int unsigned OFF_COMMIT  = 'h0C;
  localparam int unsigned OFF_STATUS  = 'h10;
  localparam int unsigned OFF_ENTRY   = 'h40;

  typedef enum logic [1:0] {
    E_FREE    = 2'd0,
    E_PENDING = 2'd1,
    E_ISSUED  = 2'd2,
    E_DONE    = 2'd3
  } entry_state_e;

  // Address is carried at full 64 bits; unused upper bits are zero.
  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic                  is_write;
  } directory_entry_t;

  typedef struct packed {
    logic       is_write;
    logic       err;
    logic [1:0] resp;
    logic [7:0] beats;
  } cpl_rec_t;

  typedef struct packed {
    logic       irq_en;
    logic       is_write;
    logic [2:0] size;
    logic [7:0] len;
  } ctrl_reg_t;

  function automatic logic [31:0] entry_word(entry_state_e st,
                                             cpl_rec_t     c);
    logic [31:0] w;
    w       = '0;
    w[14]   = c.is_write;
    w[12:5] = c.beats;
    w[4]    = c.err;
    w[3:2]  = c.resp;
    w[1:0]  = st;
    return w;
  endfunction

endpackage

// File: rtl/apb2axi_gateway_tagged_fifo.sv
// Tag FIFO holding the commit order of pending directory entries.
// Pop while empty is ignored; push and pop may share a cycle.
module apb2axi_gateway_tagged_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rp_q];

  // Circular buffer pointers, occupancy and storage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= wp_q + PW'(1);
      end
      if (do_pop) begin
        rp_q <= rp_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/apb2axi_gateway_tagged.sv
// APB-programmed AXI descriptor gateway with a tagged directory.
// Commits allocate tags, completions are stored per tag for readback.
module apb2axi_gateway_tagged
  import apb2axi_gateway_tagged_pkg::*;
#(
  parameter  int AXI_ADDR_W = 48,
  parameter  int APB_ADDR_W = 16,
  parameter  int APB_DATA_W = 32,
  parameter  int DEPTH      = 8,
  localparam int TAG_W      = $clog2(DEPTH)
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  dir_pending_valid,
  output directory_entry_t      dir_pending_entry,
  output logic [TAG_W-1:0]      dir_pending_tag,
  input  logic                  dir_pending_pop,
  input  logic                  dir_cpl_valid,
  input  logic [TAG_W-1:0]      dir_cpl_tag,
  input  logic                  dir_cpl_is_write,
  input  logic                  dir_cpl_error,
  input  logic [1:0]            dir_cpl_resp,
  input  logic [7:0]            dir_cpl_num_beats,
  output logic                  irq
);

  localparam logic [APB_ADDR_W-1:0] A_LO   = APB_ADDR_W'(OFF_ADDR_LO);
  localparam logic [APB_ADDR_W-1:0] A_HI   = APB_ADDR_W'(OFF_ADDR_HI);
  localparam logic [APB_ADDR_W-1:0] A_CTRL = APB_ADDR_W'(OFF_CTRL);
  localparam logic [APB_ADDR_W-1:0] A_CMT  = APB_ADDR_W'(OFF_COMMIT);
  localparam logic [APB_ADDR_W-1:0] A_STAT = APB_ADDR_W'(OFF_STATUS);
  localparam logic [APB_ADDR_W-1:0] A_ENT  = APB_ADDR_W'(OFF_ENTRY);
  localparam logic [APB_ADDR_W-1:0] A_NENT = APB_ADDR_W'(DEPTH);

  logic [31:0]            addr_lo_q;
  logic [AXI_ADDR_W-33:0] addr_hi_q;
  ctrl_reg_t              ctrl_q;
  logic [TAG_W-1:0]       last_tag_q;
  logic                   cpl_err_q;
  logic                   irq_q;

  entry_state_e     state_q [DEPTH];
  directory_entry_t pay_q   [DEPTH];
  cpl_rec_t         cpl_q   [DEPTH];

  logic                  access;
  logic                  hit_lo;
  logic                  hit_hi;
  logic                  hit_ctrl;
  logic                  hit_cmt;
  logic                  hit_stat;
  logic                  hit_ent;
  logic [APB_ADDR_W-1:0] ent_off;
  logic [TAG_W-1:0]      ent_tag;

  logic             sel_err;
  logic [31:0]      sel_rdata;
  logic             commit_req;
  logic             release_req;
  logic             commit;
  logic             rel;
  logic [31:0]      status_word;
  logic [6:0]       free_cnt;
  logic             any_free;
  logic             any_done;
  logic [TAG_W-1:0] alloc_tag;
  directory_entry_t snap;

  logic             fifo_empty;
  logic             fifo_full;
  logic [TAG_W-1:0] head_tag;
  logic             pop_ok;

  assign access  = PSEL & PENABLE;
  assign hit_lo   = (PADDR == A_LO);
  assign hit_hi   = (PADDR == A_HI);
  assign hit_ctrl = (PADDR == A_CTRL);
  assign hit_cmt  = (PADDR == A_CMT);
  assign hit_stat = (PADDR == A_STAT);
  assign ent_off  = PADDR - A_ENT;
  assign ent_tag  = ent_off[TAG_W+1:2];
  assign hit_ent  = (PADDR >= A_ENT) &&
                    (PADDR[1:0] == 2'b00) &&
                    ((ent_off >> 2) < A_NENT);

  // Free count, done flag and lowest-index free tag.
  always_comb begin
    free_cnt  = '0;
    any_done  = 1'b0;
    alloc_tag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == E_FREE) begin
        free_cnt  = free_cnt + 7'd1;
        alloc_tag = TAG_W'(i);
      end
      if (state_q[i] == E_DONE) begin
        any_done = 1'b1;
      end
    end
  end

  assign any_free = (free_cnt != '0);

  // Status readback word.
  always_comb begin
    status_word              = '0;
    status_word[31]          = cpl_err_q;
    status_word[24]          = ~any_free;
    status_word[22:16]       = free_cnt;
    status_word[TAG_W-1:0]   = last_tag_q;
  end

  // Descriptor snapshot taken at commit.
  always_comb begin
    snap          = '0;
    snap.addr     = ADDR_MAX_W'({addr_hi_q, addr_lo_q});
    snap.len      = ctrl_q.len;
    snap.size     = ctrl_q.size;
    snap.is_write = ctrl_q.is_write;
  end

  // APB register decode, error and read mux.
  always_comb begin
    sel_err     = 1'b0;
    sel_rdata   = '0;
    commit_req  = 1'b0;
    release_req = 1'b0;
    unique case (1'b1)
      hit_lo:   sel_rdata = addr_lo_q;
      hit_hi:   sel_rdata = 32'(addr_hi_q);
      hit_ctrl: sel_rdata = 32'(ctrl_q);
      hit_cmt: begin
        if (PWRITE) begin
          if (any_free) commit_req = 1'b1;
          else          sel_err    = 1'b1;
        end
      end
      hit_stat: sel_rdata = status_word;
      hit_ent: begin
        sel_rdata = entry_word(state_q[ent_tag],
                               cpl_q[ent_tag]);
        if (PWRITE && PWDATA[0]) begin
          if (state_q[ent_tag] == E_DONE)
            release_req = 1'b1;
          else
            sel_err = 1'b1;
        end
      end
      default: sel_err = 1'b1;
    endcase
  end

  assign commit  = access & commit_req;
  assign rel     = access & release_req;
  assign PREADY  = 1'b1;
  assign PSLVERR = access & sel_err;
  assign PRDATA  = (access & ~PWRITE & ~sel_err)
                 ? APB_DATA_W'(sel_rdata) : '0;

  apb2axi_gateway_tagged_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W)
  ) u_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (commit & ~fifo_full),
    .din_i   (alloc_tag),
    .pop_i   (dir_pending_pop),
    .dout_o  (head_tag),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign pop_ok            = dir_pending_pop & ~fifo_empty;
  assign dir_pending_valid = ~fifo_empty;
  assign dir_pending_tag   = head_tag;
  assign dir_pending_entry = pay_q[head_tag];
  assign irq               = irq_q;

  // Per-entry lifecycle: free, pending, issued, done.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= E_FREE;
        pay_q[i]   <= '0;
        cpl_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        unique case (state_q[i])
          E_FREE: begin
            if (commit && alloc_tag == TAG_W'(i)) begin
              state_q[i] <= E_PENDING;
              pay_q[i]   <= snap;
            end
          end
          E_PENDING: begin
            if (pop_ok && head_tag == TAG_W'(i))
              state_q[i] <= E_ISSUED;
          end
          E_ISSUED: begin
            if (dir_cpl_valid &&
                dir_cpl_tag == TAG_W'(i)) begin
              state_q[i]        <= E_DONE;
              cpl_q[i].is_write <= dir_cpl_is_write;
              cpl_q[i].err      <= dir_cpl_error;
              cpl_q[i].resp     <= dir_cpl_resp;
              cpl_q[i].beats    <= dir_cpl_num_beats;
            end
          end
          E_DONE: begin
            if (rel && ent_tag == TAG_W'(i)) begin
              state_q[i] <= E_FREE;
              cpl_q[i]   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Software registers, sticky completion error and interrupt.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      addr_lo_q  <= '0;
      addr_hi_q  <= '0;
      ctrl_q     <= '0;
      last_tag_q <= '0;
      cpl_err_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (access && PWRITE && hit_lo)
        addr_lo_q <= PWDATA[31:0];
      if (access && PWRITE && hit_hi)
        addr_hi_q <= PWDATA[AXI_ADDR_W-33:0];
      if (access && PWRITE && hit_ctrl)
        ctrl_q <= ctrl_reg_t'(PWDATA[12:0]);
      if (commit)
        last_tag_q <= alloc_tag;
      if (dir_cpl_valid &&
          state_q[dir_cpl_tag] != E_ISSUED)
        cpl_err_q <= 1'b1;
      irq_q <= ctrl_q.irq_en & any_done;
    end
  end

endmodule

// File: tb/tb_apb2axi_gateway_tagged.sv
// Self-checking bench for the tagged APB-to-AXI gateway.
// Directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_apb2axi_gateway_tagged;

  localparam int DEPTH = 8;
  localparam logic [15:0] A_LO   = 16'h00;
  localparam logic [15:0] A_HI   = 16'h04;
  localparam logic [15:0] A_CTRL = 16'h08;
  localparam logic [15:0] A_CMT  = 16'h0C;
  localparam logic [15:0] A_STAT = 16'h10;
  localparam logic [15:0] A_ENT  = 16'h40;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [15:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        vld;
  logic [75:0] pent;
  logic [2:0]  ptag;
  logic        pop = 1'b0;
  logic        cv = 1'b0;
  logic [2:0]  ctag = '0;
  logic        cwr = 1'b0;
  logic        cerr = 1'b0;
  logic [1:0]  cresp = '0;
  logic [7:0]  cbeats = '0;
  logic        irq;

  int total = 0;
  int bad = 0;

  apb2axi_gateway_tagged dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .PSEL              (PSEL),
    .PENABLE           (PENABLE),
    .PWRITE            (PWRITE),
    .PADDR             (PADDR),
    .PWDATA            (PWDATA),
    .PRDATA            (PRDATA),
    .PREADY            (PREADY),
    .PSLVERR           (PSLVERR),
    .dir_pending_valid (vld),
    .dir_pending_entry (pent),
    .dir_pending_tag   (ptag),
    .dir_pending_pop   (pop),
    .dir_cpl_valid     (cv),
    .dir_cpl_tag       (ctag),
    .dir_cpl_is_write  (cwr),
    .dir_cpl_error     (cerr),
    .dir_cpl_resp      (cresp),
    .dir_cpl_num_beats (cbeats),
    .irq               (irq)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- reference model ----------------
  // states: 0 free, 1 pending, 2 issued, 3 done
  int          m_state [DEPTH];
  logic [63:0] m_addr  [DEPTH];
  logic [7:0]  m_len   [DEPTH];
  logic [2:0]  m_size  [DEPTH];
  logic        m_wr    [DEPTH];
  logic [1:0]  m_resp  [DEPTH];
  logic        m_err   [DEPTH];
  logic [7:0]  m_beats [DEPTH];
  logic        m_cwr   [DEPTH];
  int          m_q[$];
  logic        m_cpl_err;
  int          m_last;
  logic [63:0] m_areg;
  logic [12:0] m_ctrl;

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_state[i] = 0; m_addr[i] = '0; m_len[i] = '0;
      m_size[i] = '0; m_wr[i] = 1'b0; m_resp[i] = '0;
      m_err[i] = 1'b0; m_beats[i] = '0; m_cwr[i] = 1'b0;
    end
    m_q.delete();
    m_cpl_err = 1'b0;
    m_last = 0;
    m_areg = '0;
    m_ctrl = '0;
  endfunction

  function automatic int m_free();
    int f = 0;
    for (int i = 0; i < DEPTH; i++) if (m_state[i] == 0) f++;
    return f;
  endfunction

  function automatic logic [31:0] m_status();
    int f = m_free();
    return (32'(m_cpl_err) << 31) | (32'(f == 0) << 24) |
           (32'(f) << 16) | 32'(m_last);
  endfunction

  function automatic logic [31:0] m_entry(int t);
    return 32'(m_state[t]) | (32'(m_resp[t]) << 2) |
           (32'(m_err[t]) << 4) | (32'(m_beats[t]) << 5) |
           (32'(m_cwr[t]) << 14);
  endfunction

  function automatic logic m_commit();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_state[i] == 0) begin
        m_state[i] = 1;
        m_addr[i]  = m_areg;
        m_len[i]   = m_ctrl[7:0];
        m_size[i]  = m_ctrl[10:8];
        m_wr[i]    = m_ctrl[11];
        m_q.push_back(i);
        m_last = i;
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic void m_pop();
    int t;
    if (m_q.size() != 0) begin
      t = m_q.pop_front();
      m_state[t] = 2;
    end
  endfunction

  function automatic void m_cpl(int t, logic w, logic e,
                                logic [1:0] r, logic [7:0] b);
    if (m_state[t] == 2) begin
      m_state[t] = 3; m_cwr[t] = w; m_err[t] = e;
      m_resp[t] = r; m_beats[t] = b;
    end else begin
      m_cpl_err = 1'b1;
    end
  endfunction

  function automatic logic m_release(int t);
    if (m_state[t] != 3) return 1'b1;
    m_state[t] = 0; m_resp[t] = '0; m_err[t] = 1'b0;
    m_beats[t] = '0; m_cwr[t] = 1'b0;
    return 1'b0;
  endfunction

  function automatic logic m_irq();
    for (int i = 0; i < DEPTH; i++)
      if (m_state[i] == 3 && m_ctrl[12]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [75:0] m_head();
    int h = m_q[0];
    return {m_addr[h], m_len[h], m_size[h], m_wr[h]};
  endfunction

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb(input logic w, input logic [15:0] a,
                     input logic [31:0] d, input logic p,
                     output logic [31:0] rd, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w;
    PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; pop = p;
    @(negedge PCLK);
    rd = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; pop = 1'b0;
  endtask

  task automatic pulse_pop();
    @(posedge PCLK); #1; pop = 1'b1;
    @(posedge PCLK); #1; pop = 1'b0;
  endtask

  task automatic pulse_cpl(input int t, input logic w,
                           input logic e, input logic [1:0] r,
                           input logic [7:0] b);
    @(posedge PCLK); #1;
    cv = 1'b1; ctag = 3'(t); cwr = w; cerr = e;
    cresp = r; cbeats = b;
    @(posedge PCLK); #1; cv = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd; logic err;
    PRESETn = 1'b0;
    idle(2);
    total++; if (PRDATA !== 32'h0) begin bad++;
      $display("FAIL rst_prdata got=%0h exp=0", PRDATA); end
    total++; if (PSLVERR !== 1'b0) begin bad++;
      $display("FAIL rst_pslverr got=%0b exp=0", PSLVERR); end
    total++; if (PREADY !== 1'b1) begin bad++;
      $display("FAIL rst_pready got=%0b exp=1", PREADY); end
    total++; if (vld !== 1'b0) begin bad++;
      $display("FAIL rst_valid got=%0b exp=0", vld); end
    total++; if (irq !== 1'b0) begin bad++;
      $display("FAIL rst_irq got=%0b exp=0", irq); end
    PRESETn = 1'b1;
    m_reset();
    apb(1'b0, A_STAT, 0, 1'b0, rd, err);
    total++; if (rd !== 32'h0008_0000) begin bad++;
      $display("FAIL rst_status got=%0h exp=80000", rd); end
  endtask

  task automatic test_commit();
    logic [31:0] rd; logic err; logic e;
    apb(1'b1, A_LO, 32'h2345_6780, 1'b0, rd, err);
    m_areg[31:0] = 32'h2345_6780;
    apb(1'b1, A_HI, 32'h1, 1'b0, rd, err);
    m_areg[47:32] = 16'h1;
    apb(1'b1, A_CTRL, 32'hA03, 1'b0, rd, err);
    m_ctrl = 13'hA03;
    apb(1'b1, A_CMT, 0, 1'b0, rd, err);
    e = m_commit();
    total++; if (err !== e) begin bad++;
      $display("FAIL commit_err got=%0b exp=%0b", err, e); end
    total++; if (vld !== 1'b1) begin bad++;
      $display("FAIL commit_valid got=%0b exp=1", vld); end
    total++; if (ptag !== 3'd0) begin bad++;
      $display("FAIL commit_tag got=%0d exp=0", ptag); end
    total++;
    if (pent !== {64'h1_2345_6780, 8'd3, 3'd2, 1'b1}) begin
      bad++;
      $display("FAIL commit_entry got=%0h exp=%0h", pent,
               {64'h1_2345_6780, 8'd3, 3'd2, 1'b1});
    end
    apb(1'b0, A_ENT, 0, 1'b0, rd, err);
    total++; if (rd !== 32'h1) begin bad++;
      $display("FAIL entry0_pending got=%0h exp=1", rd); end
  endtask

  task automatic test_fill();
    logic [31:0] rd; logic [31:0] d; logic err; logic e;
    for (int n = 1; n < DEPTH; n++) begin
      d = $urandom;
      apb(1'b1, A_LO, d, 1'b0, rd, err); m_areg[31:0] = d;
      d = $urandom & 32'hFFF;
      apb(1'b1, A_CTRL, d, 1'b0, rd, err); m_ctrl = d[12:0];
      apb(1'b1, A_CMT, 0, 1'b0, rd, err);
      e = m_commit();
      total++; if (err !== e) begin bad++;
        $display("FAIL fill_err n=%0d got=%0b exp=%0b", n, err, e); end
    end
    apb(1'b0, A_STAT, 0, 1'b0, rd, err);
    total++; if (rd !== 32'h0100_0007) begin bad++;
      $display("FAIL fill_status got=%0h exp=1000007", rd); end
    apb(1'b1, A_CMT, 0, 1'b0, rd, err);
    e = m_commit();
    total++; if (err !== 1'b1 || e !== 1'b1) begin bad++;
      $display("FAIL overflow_err got=%0b exp=1", err); end
    apb(1'b0, A_STAT, 0, 1'b0, rd, err);
    total++; if (rd !== m_status()) begin bad++;
      $display("FAIL overflow_status got=%0h exp=%0h", rd, m_status()); end
    total++; if (vld !== 1'b1 || ptag !== 3'd0) begin bad++;
      $display("FAIL overflow_head got=%0d exp=0", ptag); end
  endtask

  task automatic test_complete();
    logic [31:0] rd; logic err;
    apb(1'b1, A_CTRL, 32'h1A03, 1'b0, rd, err);
    m_ctrl = 13'h1A03;
    pulse_pop(); m_pop();
    total++; if (ptag !== 3'(m_q[0])) begin bad++;
      $display("FAIL pop_head got=%0d exp=%0d", ptag, m_q[0]); end
    total++; if (pent !== m_head()) begin bad++;
      $display("FAIL pop_entry got=%0h exp=%0h", pent, m_head()); end
    pulse_cpl(0, 1'b1, 1'b1, 2'd2, 8'd4);
    m_cpl(0, 1'b1, 1'b1, 2'd2, 8'd4);
    apb(1'b0, A_ENT, 0, 1'b0, rd, err);
    total++; if (rd !== 32'h409B || rd !== m_entry(0)) begin bad++;
      $display("FAIL cpl_entry0 got=%0h exp=409b", rd); end
    idle(1);
    total++; if (irq !== 1'b1) begin bad++;
      $display("FAIL cpl_irq got=%0b exp=1", irq); end
  endtask

  task automatic test_release();
    logic [31:0] rd; logic err; logic e;
    apb(1'b1, A_ENT, 32'h1, 1'b0, rd, err);
    e = m_release(0);
    total++; if (err !== e) begin bad++;
      $display("FAIL rel0_err got=%0b exp=%0b", err, e); end
    idle(1);
    total++; if (irq !== 1'b0) begin bad++;
      $display("FAIL rel0_irq got=%0b exp=0", irq); end
    apb(1'b0, A_STAT, 0, 1'b0, rd, err);
    total++; if (rd !== 32'h0001_0007) begin bad++;
      $display("FAIL rel0_status got=%0h exp=10007", rd); end
    apb(1'b1, A_ENT + 16'h4, 32'h1, 1'b0, rd, err);
    e = m_release(1);
    total++; if (err !== 1'b1 || e !== 1'b1) begin bad++;
      $display("FAIL rel1_err got=%0b exp=1", err); end
    apb(1'b0, A_ENT + 16'h4, 0, 1'b0, rd, err);
    total++; if (rd !== 32'h1) begin bad++;
      $display("FAIL rel1_state got=%0h exp=1", rd); end
  endtask

  task automatic test_bad_cpl();
    logic [31:0] rd; logic err;
    pulse_cpl(5, 1'b0, 1'b0, 2'd0, 8'd9);
    m_cpl(5, 1'b0, 1'b0, 2'd0, 8'd9);
    apb(1'b0, A_STAT, 0, 1'b0, rd, err);
    total++; if (rd !== 32'h8001_0007) begin bad++;
      $display("FAIL badcpl_status got=%0h exp=80010007", rd); end
    apb(1'b0, A_ENT + 16'h14, 0, 1'b0, rd, err);
    total++; if (rd !== 32'h1) begin bad++;
      $display("FAIL badcpl_entry5 got=%0h exp=1", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic err;
    logic [15:0] addrs [4];
    addrs[0] = 16'h14; addrs[1] = 16'h60;
    addrs[2] = 16'h42; addrs[3] = 16'h24;
    for (int i = 0; i < 4; i++) begin
      apb(i == 3, addrs[i], 32'hFFFF_FFFF, 1'b0, rd, err);
      total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++;
        $display("FAIL unmapped a=%0h err=%0b rd=%0h exp err=1 rd=0",
                 addrs[i], err, rd); end
    end
    apb(1'b0, A_STAT, 0, 1'b0, rd, err);
    total++; if (rd !== m_status()) begin bad++;
      $display("FAIL unmapped_status got=%0h exp=%0h", rd, m_status()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err;
    pulse_pop(); m_pop();
    pulse_cpl(1, 1'b0, 1'b0, 2'd0, 8'd1);
    m_cpl(1, 1'b0, 1'b0, 2'd0, 8'd1);
    idle(1);
    total++; if (irq !== m_irq() || irq !== 1'b1) begin bad++;
      $display("FAIL mid_pre_irq got=%0b exp=1", irq); end
    PRESETn = 1'b0;
    idle(1);
    PRESETn = 1'b1;
    m_reset();
    total++; if (vld !== 1'b0 || irq !== 1'b0) begin bad++;
      $display("FAIL mid_rst vld=%0b irq=%0b exp 0 0", vld, irq); end
    apb(1'b0, A_STAT, 0, 1'b0, rd, err);
    total++; if (rd !== 32'h0008_0000) begin bad++;
      $display("FAIL mid_rst_status got=%0h exp=80000", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; logic e;
    apb(1'b1, A_CMT, 0, 1'b0, rd, err); e = m_commit();
    apb(1'b1, A_CMT, 0, 1'b1, rd, err); m_pop(); e = m_commit();
    total++; if (err !== e) begin bad++;
      $display("FAIL b2b_err got=%0b exp=%0b", err, e); end
    total++; if (vld !== 1'b1 || ptag !== 3'd1) begin bad++;
      $display("FAIL b2b_head vld=%0b tag=%0d exp 1 1", vld, ptag); end
    apb(1'b1, A_CMT, 0, 1'b0, rd, err); e = m_commit();
    pulse_pop(); m_pop();
    total++; if (ptag !== 3'd2 || ptag !== 3'(m_q[0])) begin bad++;
      $display("FAIL b2b_order got=%0d exp=2", ptag); end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic [31:0] d; logic err; logic e;
    int op; int t; int cand[$];
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            apb(1'b1, A_LO, d, 1'b0, rd, err); m_areg[31:0] = d;
            d = $urandom;
            apb(1'b1, A_HI, d, 1'b0, rd, err); m_areg[47:32] = d[15:0];
          end
          apb(1'b1, A_CMT, 0, 1'b0, rd, err);
          e = m_commit();
          total++; if (err !== e) begin bad++;
            $display("FAIL rnd_commit n=%0d got=%0b exp=%0b", n, err, e); end
        end
        1: begin pulse_pop(); m_pop(); end
        2: begin
          cand.delete();
          for (int i = 0; i < DEPTH; i++) if (m_state[i] == 2) cand.push_back(i);
          if (cand.size() != 0 && $urandom_range(0, 4) != 0)
            t = cand[$urandom_range(0, cand.size() - 1)];
          else
            t = $urandom_range(0, DEPTH - 1);
          d = $urandom;
          pulse_cpl(t, d[0], d[1], d[3:2], d[11:4]);
          m_cpl(t, d[0], d[1], d[3:2], d[11:4]);
        end
        3: begin
          cand.delete();
          for (int i = 0; i < DEPTH; i++) if (m_state[i] == 3) cand.push_back(i);
          if (cand.size() != 0 && $urandom_range(0, 3) != 0)
            t = cand[$urandom_range(0, cand.size() - 1)];
          else
            t = $urandom_range(0, DEPTH - 1);
          apb(1'b1, A_ENT + 16'(4 * t), 32'h1, 1'b0, rd, err);
          e = m_release(t);
          total++; if (err !== e) begin bad++;
            $display("FAIL rnd_release n=%0d t=%0d got=%0b exp=%0b", n, t, err, e); end
        end
        4: begin
          t = $urandom_range(0, DEPTH - 1);
          apb(1'b0, A_ENT + 16'(4 * t), 0, 1'b0, rd, err);
          total++; if (rd !== m_entry(t) || err !== 1'b0) begin bad++;
            $display("FAIL rnd_entry n=%0d t=%0d got=%0h exp=%0h", n, t, rd, m_entry(t)); end
        end
        default: begin
          d = $urandom & 32'h1FFF;
          apb(1'b1, A_CTRL, d, 1'b0, rd, err); m_ctrl = d[12:0];
        end
      endcase
      idle(1);
      total++;
      if (vld !== (m_q.size() != 0) || irq !== m_irq()) begin bad++;
        $display("FAIL rnd_flags n=%0d vld=%0b irq=%0b exp %0b %0b",
                 n, vld, irq, m_q.size() != 0, m_irq()); end
      if (m_q.size() != 0) begin
        total++;
        if (ptag !== 3'(m_q[0]) || pent !== m_head()) begin bad++;
          $display("FAIL rnd_head n=%0d tag=%0d exp=%0d ent=%0h exp=%0h",
                   n, ptag, m_q[0], pent, m_head()); end
      end
      apb(1'b0, A_STAT, 0, 1'b0, rd, err);
      total++; if (rd !== m_status()) begin bad++;
        $display("FAIL rnd_status n=%0d got=%0h exp=%0h", n, rd, m_status()); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_commit();
    test_fill();
    test_complete();
    test_release();
    test_bad_cpl();
    test_unmapped();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
